// File: rtl/i2c_target_rx.sv
// I2C target receive engine: filters SCL/SDA, detects START/STOP, matches a 7-bit write
// address, ACKs accepted bytes and hands them to fabric as one-cycle rx_valid pulses.
module i2c_target_rx #(
    parameter logic [6:0]  TGT_ADDR = 7'h50,
    parameter int unsigned FILT_LEN = 3
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_drive_low,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ADDR     = 3'd1;
    localparam logic [2:0] ADDR_ACK = 3'd2;
    localparam logic [2:0] DATA     = 3'd3;
    localparam logic [2:0] DATA_ACK = 3'd4;
    localparam logic [2:0] IGNORE   = 3'd5;

    // Index 0 = SCL, index 1 = SDA for all input-path registers.
    logic [1:0]      s1_q, s2_q, filt_q, filt_d, prev_q;
    logic [1:0][3:0] fcnt_q, fcnt_d;

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       drive_q, drive_d;
    logic       slot_q, slot_d;
    logic       ack_q, ack_d;
    logic       rx_valid_q, rx_valid_d;
    logic       start_q, start_d;
    logic       stop_q, stop_d;
    logic       busy_q, busy_d;

    logic scl_rise, scl_fall, sda_rise, sda_fall, start_ev, stop_ev;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            filt_d[i] = filt_q[i];
            fcnt_d[i] = 4'd0;
            if (s2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == 4'(FILT_LEN - 1)) begin
                    filt_d[i] = s2_q[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + 4'd1;
                end
            end
        end
    end

    assign scl_rise = filt_q[0] & ~prev_q[0];
    assign scl_fall = ~filt_q[0] & prev_q[0];
    assign sda_rise = filt_q[1] & ~prev_q[1];
    assign sda_fall = ~filt_q[1] & prev_q[1];
    assign start_ev = sda_fall & filt_q[0];
    assign stop_ev  = sda_rise & filt_q[0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        drive_d    = drive_q;
        slot_d     = slot_q;
        ack_d      = ack_q;
        rx_valid_d = 1'b0;
        start_d    = 1'b0;
        stop_d     = 1'b0;
        busy_d     = busy_q;

        if (start_ev) begin
            drive_d = 1'b0;
            cnt_d   = 4'd0;
            slot_d  = 1'b0;
            start_d = 1'b1;
            busy_d  = 1'b1;
            state_d = ADDR;
        end else if (stop_ev) begin
            drive_d = 1'b0;
            cnt_d   = 4'd0;
            slot_d  = 1'b0;
            stop_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
        end else begin
            case (state_q)
                ADDR, DATA: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], filt_q[1]};
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            slot_d = 1'b0;
                            if (state_q == ADDR) begin
                                state_d = (shift_d[7:1] == TGT_ADDR && !shift_d[0]) ?
                                          ADDR_ACK : IGNORE;
                            end else begin
                                ack_d   = rx_ready;
                                state_d = DATA_ACK;
                                if (rx_ready) begin
                                    rx_data_d  = shift_d;
                                    rx_valid_d = 1'b1;
                                end
                            end
                        end
                    end
                end
                // First SCL fall opens the ACK slot, the second closes it.
                ADDR_ACK, DATA_ACK: begin
                    if (scl_fall) begin
                        if (!slot_q) begin
                            drive_d = (state_q == ADDR_ACK) ? 1'b1 : ack_q;
                            slot_d  = 1'b1;
                        end else begin
                            drive_d = 1'b0;
                            slot_d  = 1'b0;
                            cnt_d   = 4'd0;
                            state_d = (state_q == ADDR_ACK || ack_q) ? DATA : IGNORE;
                        end
                    end
                end
                IGNORE:  drive_d = 1'b0;
                IDLE:    drive_d = 1'b0;
                default: begin
                    drive_d = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            s1_q       <= 2'b11;
            s2_q       <= 2'b11;
            filt_q     <= 2'b11;
            prev_q     <= 2'b11;
            fcnt_q     <= '0;
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            shift_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            drive_q    <= 1'b0;
            slot_q     <= 1'b0;
            ack_q      <= 1'b0;
            rx_valid_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            s1_q       <= {sda_in, scl_in};
            s2_q       <= s1_q;
            filt_q     <= filt_d;
            prev_q     <= filt_q;
            fcnt_q     <= fcnt_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            drive_q    <= drive_d;
            slot_q     <= slot_d;
            ack_q      <= ack_d;
            rx_valid_q <= rx_valid_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            busy_q     <= busy_d;
        end
    end

    assign sda_drive_low = drive_q;
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign start_det     = start_q;
    assign stop_det      = stop_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: a bit-banged I2C master with a transaction-level model of
// expected ACKs and delivered bytes; a scoreboard monitor checks every rx_valid.
`timescale 1ns/1ps
module tb_i2c_target_rx;

    localparam int Q    = 10;
    localparam int FILT = 3;

    logic       CLK = 1'b0;
    logic       rst = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       rx_ready = 1'b0;
    logic       sda_drive_low, rx_valid, start_det, stop_det, busy;
    logic [7:0] rx_data;
    logic       sda_line;

    assign sda_line = m_sda & ~sda_drive_low;

    always #10 CLK = ~CLK;

    i2c_target_rx #(.TGT_ADDR(7'h50), .FILT_LEN(FILT)) dut (
        .CLK           (CLK),
        .rst           (rst),
        .scl_in        (m_scl),
        .sda_in        (sda_line),
        .sda_drive_low (sda_drive_low),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .start_det     (start_det),
        .stop_det      (stop_det),
        .busy          (busy)
    );

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];
    int         n_start = 0, n_stop = 0, exp_start = 0, exp_stop = 0;
    int         model_phase = 3;  // 0 expect address, 1 accepting data, 2 ignoring, 3 idle
    logic       prev_drv = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor and bus-rule checks.
    always @(negedge CLK) begin
        if (rst) begin
            if (rx_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rx_unexpected: got rx_data %0h expected no rx_valid", rx_data);
                end else begin
                    check("rx_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
                end
            end
            if (start_det) n_start++;
            if (stop_det) n_stop++;
        end
        if (sda_drive_low !== prev_drv) begin
            check("drive_change_scl_low", {31'h0, m_scl}, 32'h0);
        end
        prev_drv = sda_drive_low;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic m_start();
        m_sda = 1'b1;
        cyc(Q);
        m_scl = 1'b1;
        cyc(Q);
        m_sda = 1'b0;
        cyc(Q);
        m_scl = 1'b0;
        cyc(Q);
        exp_start++;
        model_phase = 0;
        check("busy_after_start", {31'h0, busy}, 32'h1);
    endtask

    task automatic m_stop();
        m_sda = 1'b0;
        cyc(Q);
        m_scl = 1'b1;
        cyc(Q);
        m_sda = 1'b1;
        cyc(Q);
        exp_stop++;
        model_phase = 3;
        check("busy_after_stop", {31'h0, busy}, 32'h0);
    endtask

    task automatic m_bit(input logic b, input bit glitch);
        m_sda = b;
        cyc(3);
        if (glitch) begin
            m_scl = 1'b1;
            cyc(FILT - 1);
            m_scl = 1'b0;
        end
        cyc(Q);
        m_scl = 1'b1;
        cyc(Q);
        check("bus_bit", {31'h0, sda_line}, {31'h0, b});
        if (glitch) begin
            m_scl = 1'b0;
            cyc(FILT - 1);
            m_scl = 1'b1;
        end
        cyc(Q);
        m_scl = 1'b0;
        cyc(Q);
    endtask

    task automatic m_ack(output bit ack);
        m_sda = 1'b1;
        cyc(Q);
        m_scl = 1'b1;
        cyc(Q / 2);
        ack = !sda_line;
        cyc(Q / 2 + Q);
        m_scl = 1'b0;
        cyc(Q);
    endtask

    // Transaction-level model: address must be 0x50 write; then each byte is ACKed and
    // delivered while rx_ready holds; the first refusal ignores the rest of the transfer.
    task automatic send_byte(input logic [7:0] b, input bit rdy, input bit glitch,
                             input string nm);
        bit exp_ack, ack;
        rx_ready = rdy;
        case (model_phase)
            0: begin
                exp_ack = (b[7:1] == 7'h50) && !b[0];
                model_phase = exp_ack ? 1 : 2;
            end
            1: begin
                exp_ack = rdy;
                if (rdy) exp_q.push_back(b);
                else model_phase = 2;
            end
            default: exp_ack = 1'b0;
        endcase
        for (int i = 7; i >= 0; i--) m_bit(b[i], glitch);
        m_ack(ack);
        check({nm, "_ack"}, {31'h0, ack}, {31'h0, exp_ack});
    endtask

    task automatic check_events(input string nm);
        check({nm, "_start_cnt"}, n_start, exp_start);
        check({nm, "_stop_cnt"}, n_stop, exp_stop);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(3);
        check("rst_drive", {31'h0, sda_drive_low}, 32'h0);
        check("rst_rx_data", {24'h0, rx_data}, 32'h0);
        check("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_start", {31'h0, start_det}, 32'h0);
        check("rst_stop", {31'h0, stop_det}, 32'h0);
        rst = 1'b1;
        cyc(Q);

        m_start();
        send_byte(8'hA0, 1'b1, 1'b0, "t1_addr");
        send_byte(8'hA5, 1'b1, 1'b0, "t1_d0");
        send_byte(8'h3C, 1'b1, 1'b0, "t1_d1");
        m_stop();
        check_events("t1");

        m_start();
        send_byte(8'hA2, 1'b1, 1'b0, "t2_addr");
        send_byte(8'h33, 1'b1, 1'b0, "t2_d0");
        check("t2_busy", {31'h0, busy}, 32'h1);
        m_stop();
        check_events("t2");

        m_start();
        send_byte(8'hA1, 1'b1, 1'b0, "t3_addr");
        send_byte(8'h44, 1'b1, 1'b0, "t3_d0");
        m_stop();

        m_start();
        send_byte(8'hA0, 1'b1, 1'b0, "t4_addr");
        send_byte(8'h12, 1'b1, 1'b0, "t4_d0");
        send_byte(8'h77, 1'b0, 1'b0, "t4_d1");
        send_byte(8'h55, 1'b1, 1'b0, "t4_d2");
        m_stop();
        check_events("t4");

        m_start();
        send_byte(8'hA0, 1'b1, 1'b0, "t5_addr");
        for (int i = 0; i < 4; i++) m_bit(1'($urandom_range(0, 1)), 1'b0);
        m_start();
        send_byte(8'hA0, 1'b1, 1'b0, "t5_addr2");
        send_byte(8'h11, 1'b1, 1'b0, "t5_d0");
        m_stop();
        check_events("t5");

        m_start();
        send_byte(8'hA0, 1'b1, 1'b1, "t6_addr");
        send_byte(8'h5A, 1'b1, 1'b1, "t6_d0");
        m_stop();

        // Reset while the target holds the address ACK.
        m_start();
        for (int i = 7; i >= 0; i--) m_bit(1'(8'hA0 >> i), 1'b0);
        m_sda = 1'b1;
        cyc(Q / 2);
        check("drv_before_rst", {31'h0, sda_drive_low}, 32'h1);
        rst = 1'b0;
        #1;
        check("drv_async_rst", {31'h0, sda_drive_low}, 32'h0);
        check("busy_async_rst", {31'h0, busy}, 32'h0);
        cyc(2);
        rst = 1'b1;
        model_phase = 3;
        m_scl = 1'b1;
        cyc(Q);
        m_scl = 1'b0;
        cyc(Q);
        send_byte(8'h12, 1'b1, 1'b0, "t7_post_rst");
        m_stop();
        check_events("t7");

        for (int t = 0; t < 12; t++) begin
            logic [7:0] addr;
            int nb;
            case ($urandom_range(0, 3))
                0, 1:    addr = 8'hA0;
                2:       addr = 8'hA2;
                default: addr = 8'hA1;
            endcase
            nb = $urandom_range(1, 3);
            m_start();
            send_byte(addr, 1'b1, 1'b0, "rnd_addr");
            for (int k = 0; k < nb; k++) begin
                send_byte(8'($urandom), ($urandom_range(0, 4) != 0), 1'b0, "rnd_data");
            end
            m_stop();
        end
        check_events("rnd");

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) cyc(1);
        check("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
